// File: rtl/wb_stage_pkg.sv
// Shared types and helpers for the write-back stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Bit numbering note: the ISA numbers bits big-endian (bit 0 = MSB). RTL
// vectors here are declared [31:0], so ISA bit k lives at vector index 31-k.
package wb_stage_pkg;

    // Source of the MEM/WB write data.
    typedef enum logic [1:0] {
        SEL_ALU,
        SEL_LOAD,
        SEL_LINK
    } wb_sel_e;

    // One queued FPU result.
    typedef struct packed {
        logic [4:0]  rw;
        logic        dst_fpr;
        logic [31:0] data;
    } fpq_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Extract and extend a byte/halfword lane from a big-endian memory word.
    // off is the two low address bits (ISA bits [30:31]); ISA off[0] is
    // vector off[1]. Misaligned halfwords fall back to the even lane.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] mem,
        input logic [1:0]  off,
        input logic        byte_op,
        input logic        half_op,
        input logic        sign_ext
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'd0:    lane_b = mem[31:24];
            2'd1:    lane_b = mem[23:16];
            2'd2:    lane_b = mem[15:8];
            default: lane_b = mem[7:0];
        endcase
        lane_h = off[1] ? mem[15:0] : mem[31:16];
        if (byte_op) begin
            res = {{24{sign_ext & lane_b[7]}}, lane_b};
        end else if (half_op) begin
            res = {{16{sign_ext & lane_h[15]}}, lane_h};
        end else begin
            res = mem;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_fpq.sv
// In-order FIFO for FPU results awaiting a free register-write slot.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: full_o is high when all entries are used; pushes while full are dropped.
//
// Ports: clk/reset (sync, active-low); push_i/push_dat_i write side;
// pop_i read side; head_o oldest entry; full_o/empty_o/count_o occupancy.
module wb_fpq
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fpq_entry_t    push_dat_i,
    input  logic          pop_i,
    output fpq_entry_t    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fpq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: formats load data and arbitrates the single register write port
// between the MEM/WB record and queued FPU results. Latency: 1 cycle (registered outputs).
// Backpressure: fpu_ready low when the queue is full; wb_stall only with the starve guard.
//
// Optional feature macro: WB_STARVE_GUARD_EN. When defined, a queued FPU result that
// has waited STARVE_LIMIT cycles takes the port and the MEM/WB record is held
// (wb_stall=1). When undefined, wb_stall is tied low and the queue drains only in idle slots.
//
// Ports: clk, reset (sync, active-low); wb_* MEM/WB record in, wb_stall out;
// fpu_* FPU result in, fpu_ready out; BUS_W/FBUS_W/Rw_out/reg_we_out/f_reg_we_out
// towards gprFile/fprFile.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int FPQ_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rw,
    input  logic        wb_reg_we,
    input  logic        wb_f_reg_we,
    input  logic        wb_mem_to_reg,
    input  logic        wb_byte_op,
    input  logic        wb_halfword_op,
    input  logic        wb_sign_ext,
    input  logic        wb_jal,
    input  logic [31:0] wb_alu_result,
    input  logic [31:0] wb_mem_data,
    input  logic [31:0] wb_link_addr,
    output logic        wb_stall,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_rw,
    input  logic        fpu_dst_fpr,
    input  logic [31:0] fpu_result,
    output logic        fpu_ready,
    output logic [31:0] BUS_W,
    output logic [31:0] FBUS_W,
    output logic [4:0]  Rw_out,
    output logic        reg_we_out,
    output logic        f_reg_we_out
);
    localparam int CW = $clog2(FPQ_DEPTH) + 1;

    fpq_entry_t    q_push_dat, q_head;
    logic          q_push, q_pop, q_full, q_empty;
    logic [CW-1:0] q_count;

    wb_sel_e       sel;
    logic [31:0]   wb_dat;
    logic          wb_write;
    logic          force_head;

    logic [31:0]   dat_q, dat_d;
    logic [4:0]    rw_q, rw_d;
    logic          reg_we_q, reg_we_d;
    logic          f_reg_we_q, f_reg_we_d;

    // ------------------------------------------------------------------
    // FPU result queue
    // ------------------------------------------------------------------
    assign q_push_dat = '{rw: fpu_rw, dst_fpr: fpu_dst_fpr, data: fpu_result};
    assign fpu_ready  = ~q_full;
    assign q_push     = fpu_valid & ~q_full;

    wb_fpq #(
        .DEPTH (FPQ_DEPTH)
    ) u_fpq (
        .clk        (clk),
        .reset      (reset),
        .push_i     (q_push),
        .push_dat_i (q_push_dat),
        .pop_i      (q_pop),
        .head_o     (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_head = ~q_empty & (starve_q >= SW'(STARVE_LIMIT));

    // Counts cycles the head has been passed over; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (q_pop) begin
            starve_d = '0;
        end else if (~q_empty && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_head = 1'b0;

    logic unused_cfg;
    assign unused_cfg = (STARVE_LIMIT != 0);
`endif

    assign wb_stall = force_head;

    // Occupancy count is informational here; full/empty drive the logic.
    logic unused_count;
    assign unused_count = ^q_count;

    // ------------------------------------------------------------------
    // MEM/WB data selection
    // ------------------------------------------------------------------
    always_comb begin
        if (wb_jal) begin
            sel = SEL_LINK;
        end else if (wb_mem_to_reg) begin
            sel = SEL_LOAD;
        end else begin
            sel = SEL_ALU;
        end
        case (sel)
            SEL_LINK: wb_dat = wb_link_addr;
            SEL_LOAD: wb_dat = fmt_load(wb_mem_data, wb_alu_result[1:0],
                                        wb_byte_op, wb_halfword_op, wb_sign_ext);
            default:  wb_dat = wb_alu_result;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-port arbitration
    // ------------------------------------------------------------------
    // A record with no enables does not occupy the port; an r0 write does.
    assign wb_write = wb_valid & (wb_reg_we | wb_f_reg_we);
    assign q_pop    = ~q_empty & (~wb_write | force_head);

    always_comb begin
        dat_d      = dat_q;
        rw_d       = rw_q;
        reg_we_d   = 1'b0;
        f_reg_we_d = 1'b0;
        if (q_pop) begin
            dat_d      = q_head.data;
            rw_d       = q_head.rw;
            reg_we_d   = ~q_head.dst_fpr & (q_head.rw != REG_ZERO);
            f_reg_we_d = q_head.dst_fpr;
        end else if (wb_write) begin
            dat_d      = wb_dat;
            rw_d       = wb_rw;
            reg_we_d   = wb_reg_we & (wb_rw != REG_ZERO);
            f_reg_we_d = wb_f_reg_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dat_q      <= '0;
            rw_q       <= REG_ZERO;
            reg_we_q   <= 1'b0;
            f_reg_we_q <= 1'b0;
        end else begin
            dat_q      <= dat_d;
            rw_q       <= rw_d;
            reg_we_q   <= reg_we_d;
            f_reg_we_q <= f_reg_we_d;
        end
    end

    assign BUS_W        = dat_q;
    assign FBUS_W       = dat_q;
    assign Rw_out       = rw_q;
    assign reg_we_out   = reg_we_q;
    assign f_reg_we_out = f_reg_we_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases with literal expectations plus randomized
// traffic checked every cycle against a queue-based reference model.
// Builds with or without WB_STARVE_GUARD_EN.
module tb_wb_stage;
    localparam int FPQ_DEPTH    = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_reg_we, wb_f_reg_we, wb_mem_to_reg;
    logic        wb_byte_op, wb_halfword_op, wb_sign_ext, wb_jal;
    logic [4:0]  wb_rw;
    logic [31:0] wb_alu_result, wb_mem_data, wb_link_addr;
    logic        wb_stall;
    logic        fpu_valid, fpu_dst_fpr, fpu_ready;
    logic [4:0]  fpu_rw;
    logic [31:0] fpu_result;
    logic [31:0] BUS_W, FBUS_W;
    logic [4:0]  Rw_out;
    logic        reg_we_out, f_reg_we_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_stage #(.FPQ_DEPTH(FPQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_reg_we(wb_reg_we),
        .wb_f_reg_we(wb_f_reg_we), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_byte_op(wb_byte_op), .wb_halfword_op(wb_halfword_op),
        .wb_sign_ext(wb_sign_ext), .wb_jal(wb_jal),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_link_addr(wb_link_addr), .wb_stall(wb_stall),
        .fpu_valid(fpu_valid), .fpu_rw(fpu_rw), .fpu_dst_fpr(fpu_dst_fpr),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready),
        .BUS_W(BUS_W), .FBUS_W(FBUS_W), .Rw_out(Rw_out),
        .reg_we_out(reg_we_out), .f_reg_we_out(f_reg_we_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: results queue, wait counter and the expected
    // contents of the write port one cycle ahead.
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  rw;
        logic        fpr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          waited = 0;
    bit          known = 0;
    bit          exp_wr = 0, exp_rwe = 0, exp_fwe = 0;
    logic [31:0] exp_dat = '0;
    logic [4:0]  exp_rw = '0;

    function automatic logic [31:0] m_load(input logic [31:0] mem, input logic [1:0] off,
                                           input logic bop, input logic hop, input logic sx);
        logic [31:0] v;
        int          w;
        if (bop) begin
            v = (mem >> (8 * (3 - int'(off)))) & 32'hFF;
            w = 8;
        end else if (hop) begin
            v = (mem >> (off[1] ? 0 : 16)) & 32'hFFFF;
            w = 16;
        end else begin
            return mem;
        end
        if (sx && v[w-1]) v = v | (32'hFFFF_FFFF << w);
        return v;
    endfunction

    always @(negedge clk) begin : compare
        bit   wb_write, force_now, drain;
        ent_t e;
        force_now = GUARD && (mq.size() != 0) && (waited >= STARVE_LIMIT);
        if (known) begin
            chk("reg_we_out", reg_we_out, exp_rwe);
            chk("f_reg_we_out", f_reg_we_out, exp_fwe);
            if (exp_wr) begin
                chk("BUS_W", BUS_W, exp_dat);
                chk("FBUS_W", FBUS_W, exp_dat);
                chk("Rw_out", Rw_out, exp_rw);
            end
            chk("fpu_ready", fpu_ready, mq.size() < FPQ_DEPTH);
            chk("wb_stall", wb_stall, force_now);
        end
        if (!reset) begin
            mq.delete();
            waited  = 0;
            known   = 1;
            exp_wr  = 1;
            exp_dat = '0;
            exp_rw  = '0;
            exp_rwe = 0;
            exp_fwe = 0;
        end else begin
            bit ready_now;
            ready_now = mq.size() < FPQ_DEPTH;
            wb_write  = wb_valid && (wb_reg_we || wb_f_reg_we);
            drain     = (mq.size() != 0) && (!wb_write || force_now);
            exp_wr = 0; exp_rwe = 0; exp_fwe = 0;
            if (drain) begin
                e = mq.pop_front();
                exp_wr  = 1;
                exp_dat = e.data;
                exp_rw  = e.rw;
                exp_fwe = e.fpr;
                exp_rwe = !e.fpr && (e.rw != 0);
                waited  = 0;
            end else begin
                if (wb_write) begin
                    exp_wr  = 1;
                    exp_dat = wb_jal ? wb_link_addr :
                              wb_mem_to_reg ? m_load(wb_mem_data, wb_alu_result[1:0],
                                                     wb_byte_op, wb_halfword_op, wb_sign_ext)
                                            : wb_alu_result;
                    exp_rw  = wb_rw;
                    exp_rwe = wb_reg_we && (wb_rw != 0);
                    exp_fwe = wb_f_reg_we;
                end
                if (mq.size() != 0 && waited < STARVE_LIMIT) waited++;
            end
            if (fpu_valid && ready_now) begin
                e.rw = fpu_rw; e.fpr = fpu_dst_fpr; e.data = fpu_result;
                mq.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        wb_valid = 0; wb_rw = '0; wb_reg_we = 0; wb_f_reg_we = 0;
        wb_mem_to_reg = 0; wb_byte_op = 0; wb_halfword_op = 0;
        wb_sign_ext = 0; wb_jal = 0;
        wb_alu_result = '0; wb_mem_data = '0; wb_link_addr = '0;
    endtask

    task automatic alu_wb(input logic [4:0] rw, input logic [31:0] val);
        idle_wb();
        wb_valid = 1; wb_rw = rw; wb_reg_we = 1; wb_alu_result = val;
    endtask

    task automatic fpu_push(input logic v, input logic [4:0] rw, input logic fpr,
                            input logic [31:0] d);
        fpu_valid = v; fpu_rw = rw; fpu_dst_fpr = fpr; fpu_result = d;
    endtask

    task automatic rand_wb();
        int kind;
        idle_wb();
        kind = $urandom_range(0, 4);
        wb_valid      = 1;
        wb_rw         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        wb_alu_result = $urandom;
        wb_mem_data   = $urandom;
        wb_link_addr  = $urandom;
        case (kind)
            0: wb_reg_we = 1;
            1: begin
                wb_reg_we = 1; wb_mem_to_reg = 1;
                wb_byte_op = $urandom_range(0, 1);
                wb_halfword_op = !wb_byte_op && ($urandom_range(0, 1) == 1);
                wb_sign_ext = $urandom_range(0, 1);
            end
            2: begin
                wb_jal = 1; wb_reg_we = 1; wb_rw = 5'd31;
                wb_mem_to_reg = $urandom_range(0, 1);
            end
            3: begin
                wb_f_reg_we = 1; wb_mem_to_reg = $urandom_range(0, 1);
            end
            default: ;
        endcase
    endtask

    initial begin : stim
        int  n;
        int  dens;
        bit  held;
        reset = 0;
        idle_wb();
        fpu_push(1, 5'd2, 1, 32'hAAAA_5555);

        // Reset held 3 cycles while the FPU offers results.
        repeat (3) step();
        reset = 1;
        fpu_push(0, 0, 0, 0);
        chk("rst reg_we", reg_we_out, 0);
        chk("rst f_reg_we", f_reg_we_out, 0);
        chk("rst BUS_W", BUS_W, 0);
        chk("rst FBUS_W", FBUS_W, 0);
        chk("rst Rw", Rw_out, 0);
        chk("rst fpu_ready", fpu_ready, 1);
        chk("rst wb_stall", wb_stall, 0);
        repeat (3) step();
        chk("rst queue empty", f_reg_we_out, 0);

        // LB, sign-extend, offset 1.
        idle_wb();
        wb_valid = 1; wb_rw = 5'd5; wb_reg_we = 1; wb_mem_to_reg = 1;
        wb_byte_op = 1; wb_sign_ext = 1;
        wb_alu_result = 32'h0000_1001; wb_mem_data = 32'h12F4_5678;
        step();
        chk("LB BUS_W", BUS_W, 32'hFFFF_FFF4);
        chk("LB reg_we", reg_we_out, 1);
        chk("LB Rw", Rw_out, 5);

        // LHU, misaligned offset 3 uses the lower halfword.
        wb_byte_op = 0; wb_halfword_op = 1; wb_sign_ext = 0;
        wb_alu_result = 32'h0000_2003; wb_mem_data = 32'h1234_ABCD;
        step();
        chk("LHU BUS_W", BUS_W, 32'h0000_ABCD);

        // ALU write to r0 is suppressed.
        alu_wb(5'd0, 32'hDEAD_BEEF);
        step();
        chk("r0 reg_we", reg_we_out, 0);

        // JAL writes the link address.
        idle_wb();
        wb_valid = 1; wb_rw = 5'd31; wb_reg_we = 1; wb_jal = 1;
        wb_mem_to_reg = 1; wb_link_addr = 32'h100; wb_alu_result = 32'h55;
        step();
        chk("JAL Rw", Rw_out, 31);
        chk("JAL BUS_W", BUS_W, 32'h100);
        chk("JAL reg_we", reg_we_out, 1);

        // FPU result waits behind three MEM/WB writes.
        idle_wb(); step();
        alu_wb(5'd7, 32'h7); fpu_push(1, 5'd3, 1, 32'h3F80_0000);
        step();
        fpu_push(0, 0, 0, 0);
        chk("fq busy1 f_we", f_reg_we_out, 0);
        alu_wb(5'd8, 32'h8); step();
        chk("fq busy2 f_we", f_reg_we_out, 0);
        alu_wb(5'd9, 32'h9); step();
        chk("fq busy3 f_we", f_reg_we_out, 0);
        idle_wb(); step();
        chk("fq drain f_we", f_reg_we_out, 1);
        chk("fq drain FBUS", FBUS_W, 32'h3F80_0000);
        chk("fq drain Rw", Rw_out, 3);
        chk("fq drain reg_we", reg_we_out, 0);

        // Fill the queue to depth 2 under traffic.
        alu_wb(5'd10, 32'hA); fpu_push(1, 5'd4, 1, 32'h4000_0000);
        step();
        chk("fill1 ready", fpu_ready, 1);
        alu_wb(5'd11, 32'hB); fpu_push(1, 5'd6, 0, 32'h4040_0000);
        step();
        chk("fill2 ready", fpu_ready, 0);
        alu_wb(5'd12, 32'hC); fpu_push(1, 5'd8, 1, 32'h4080_0000);
        step();
        chk("fill3 ready", fpu_ready, 0);
        idle_wb(); fpu_push(0, 0, 0, 0);
        step();
        chk("order1 FBUS", FBUS_W, 32'h4000_0000);
        step();
        chk("order2 BUS", BUS_W, 32'h4040_0000);
        chk("order2 reg_we", reg_we_out, 1);
        step();
        chk("order3 idle", f_reg_we_out | reg_we_out, 0);

        // Reset mid-operation discards queued results.
        alu_wb(5'd13, 32'hD); fpu_push(1, 5'd1, 1, 32'h1111_1111);
        step();
        fpu_push(1, 5'd2, 1, 32'h2222_2222);
        step();
        reset = 0; fpu_push(0, 0, 0, 0);
        step();
        reset = 1; idle_wb();
        step();
        chk("midrst ready", fpu_ready, 1);
        step();
        chk("midrst f_we", f_reg_we_out, 0);

`ifdef WB_STARVE_GUARD_EN
        // Continuous traffic with one queued result forces a stall.
        idle_wb(); step();
        alu_wb(5'd14, 32'h14); fpu_push(1, 5'd6, 1, 32'hCAFE_0001);
        step();
        fpu_push(0, 0, 0, 0);
        n = 1;
        while (!wb_stall && n < 20) begin
            alu_wb(5'd15, 32'($unsigned(n)));
            step();
            n++;
        end
        chk("starve wait", n, STARVE_LIMIT + 1);
        alu_wb(5'd9, 32'h77);
        step();
        chk("starve f_we", f_reg_we_out, 1);
        chk("starve FBUS", FBUS_W, 32'hCAFE_0001);
        step();
        chk("held reg_we", reg_we_out, 1);
        chk("held BUS", BUS_W, 32'h77);
        idle_wb();
`endif

        // Randomized traffic.
        held = 0;
        dens = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) dens = $urandom_range(0, 4);
            if (!held) begin
                if ($urandom_range(0, 3) < dens) rand_wb();
                else idle_wb();
            end
            fpu_push($urandom_range(0, 2) == 0, 5'($urandom), 1'($urandom), $urandom);
            reset = ($urandom_range(0, 299) != 0);
            held  = wb_stall && reset;
            step();
        end
        reset = 1; idle_wb(); fpu_push(0, 0, 0, 0);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
